// File: rtl/bist_pkg.sv
// Shared types, constants and next-state helpers for the BIST stimulus/response block.
// The LFSR and MISR update rules live here so the top and the MISR agree on them.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int                LFSR_W       = 5;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 5'h1F;
  localparam int                SIG_W        = 16;
  localparam logic [SIG_W-1:0]  MISR_POLY    = 16'h1021;
  localparam int                CNT_W        = 16;

  // x^5 + x^3 + 1 Fibonacci LFSR, maximal length (31 states)
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s, input logic din);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : '0) ^ {{(SIG_W-1){1'b0}}, din};
  endfunction

endpackage

// File: rtl/bist_stim_resp_if.sv
// Handshake/bus bundle between the BIST controller and its driver/observer.
interface bist_stim_resp_if;
  logic                          start;
  logic [bist_pkg::CNT_W-1:0]    pattern_count;
  logic [bist_pkg::SIG_W-1:0]    golden_sig;
  logic                          dut_resp;
  logic [bist_pkg::LFSR_W-1:0]   stim;
  logic                          busy;
  logic                          done;
  logic                          pass;
  logic [bist_pkg::SIG_W-1:0]    signature;

  modport master (
    output start, pattern_count, golden_sig, dut_resp,
    input  stim, busy, done, pass, signature
  );

  modport slave (
    input  start, pattern_count, golden_sig, dut_resp,
    output stim, busy, done, pass, signature
  );
endinterface

// File: rtl/bist_misr16.sv
// 16-bit multiple-input signature register; clear has priority over capture.
module bist_misr16
  import bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear)   sig_d = '0;
    else if (en) sig_d = misr_next(sig_q, din);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_stim_resp.sv
// BIST controller: drives N LFSR patterns into a DUT and compacts its delayed
// responses into a MISR signature, then reports pass against a golden value.
module bist_stim_resp
  import bist_pkg::*;
#(
  parameter int                LAT    = 2,
  parameter logic [LFSR_W-1:0] SEED   = SEED_DEFAULT,
  parameter int                GOLD_W = SIG_W
) (
  input  logic              I1294_clk,
  input  logic              I1301_rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  pattern_count,
  input  logic [GOLD_W-1:0] golden_sig,
  input  logic              dut_resp,
  output logic [LFSR_W-1:0] stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [GOLD_W-1:0] signature
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [GOLD_W-1:0] golden_q, golden_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              pass_q, pass_d;
  logic [LAT-1:0]    vld_q, vld_d;
  logic [LAT:0]      vld_ext;
  logic              start_ok, run, cap_en;
  logic [GOLD_W-1:0] sig, sig_next;

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign run      = (state_q == ST_RUN);
  assign cap_en   = vld_q[LAT-1];
  // pass is decided on the same edge as the final capture, so look one step ahead
  assign sig_next = cap_en ? misr_next(sig, dut_resp) : sig;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    golden_d = golden_q;
    lfsr_d   = lfsr_q;
    pass_d   = pass_q;
    vld_ext  = {vld_q, run};
    vld_d    = vld_ext[LAT-1:0];
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          n_d      = pattern_count;
          golden_d = golden_sig;
          lfsr_d   = SEED;
          cnt_d    = '0;
          if (pattern_count == '0) begin
            state_d = ST_DONE;
            pass_d  = (golden_sig == '0);
          end else begin
            state_d = ST_RUN;
            pass_d  = 1'b0;
          end
        end
      end
      ST_RUN: begin
        // LFSR stays on the last pattern so stim holds through DRAIN/DONE
        if (cnt_q == n_q - CNT_W'(1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          lfsr_d = lfsr_next(lfsr_q);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(LAT - 1)) begin
          state_d = ST_DONE;
          pass_d  = (sig_next == golden_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I1294_clk or posedge I1301_rst) begin
    if (I1301_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      golden_q <= '0;
      lfsr_q   <= SEED;
      pass_q   <= 1'b0;
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      golden_q <= golden_d;
      lfsr_q   <= lfsr_d;
      pass_q   <= pass_d;
      vld_q    <= vld_d;
    end
  end

  bist_misr16 u_misr (
    .clk   (I1294_clk),
    .rst   (I1301_rst),
    .clear (start_ok),
    .en    (cap_en),
    .din   (dut_resp),
    .sig   (sig)
  );

  assign stim      = lfsr_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign signature = sig;

endmodule

// File: tb/tb_bist_stim_resp.sv
// Bench for bist_stim_resp: a behavioural run model plus an emulated DUT whose
// response is a function of the stimulus LAT cycles earlier.
module tb_bist_stim_resp;
  localparam int LAT = 2;

  logic       clk;
  logic       rst;
  int         cyc;
  int         checks;
  int         errors;
  int         run_t0;
  int         exp_n;
  int         resp_mode;
  bit         model_on;
  logic [15:0] exp_sig;
  logic       exp_pass;
  logic [4:0] seq  [0:63];
  logic [4:0] obs  [0:63];
  logic [4:0] hist [0:LAT];
  int         busy_cnt;
  int         done_k;

  bist_stim_resp_if bus ();

  bist_stim_resp #(.LAT(LAT)) dut (
    .I1294_clk     (clk),
    .I1301_rst     (rst),
    .start         (bus.start),
    .pattern_count (bus.pattern_count),
    .golden_sig    (bus.golden_sig),
    .dut_resp      (bus.dut_resp),
    .stim          (bus.stim),
    .busy          (bus.busy),
    .done          (bus.done),
    .pass          (bus.pass),
    .signature     (bus.signature)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Emulated DUT under test: output at cycle t depends on stim at cycle t-LAT
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = bus.stim;
    case (resp_mode)
      0:       bus.dut_resp = 1'b0;
      1:       bus.dut_resp = 1'b1;
      default: bus.dut_resp = ^hist[LAT];
    endcase
  end

  // Pattern sequence and expected signature from the polynomial definitions
  task automatic build_model(input int n, input int mode);
    int s, sg, r;
    s  = 'h1F;
    sg = 0;
    for (int i = 0; i < 64; i++) begin
      seq[i] = s[4:0];
      if (i < n) begin
        r  = (mode == 0) ? 0 : (mode == 1) ? 1 : int'(^s[4:0]);
        sg = ((sg << 1) & 'hFFFF) ^ ((((sg >> 15) & 1) != 0) ? 'h1021 : 0) ^ r;
      end
      s = ((s << 1) & 'h1E) | (((s >> 4) ^ (s >> 2)) & 1);
    end
    exp_sig = sg[15:0];
  endtask

  always @(negedge clk) begin : compare
    int k, end_k;
    if (model_on) begin
      k     = cyc - run_t0;
      end_k = (exp_n == 0) ? 0 : exp_n + LAT;
      chk("busy", 32'(bus.busy), 32'(k < end_k));
      chk("done", 32'(bus.done), 32'(k >= end_k));
      if (exp_n > 0)
        chk("stim", 32'(bus.stim), 32'((k < exp_n) ? seq[k] : seq[exp_n-1]));
      if (k >= end_k) begin
        chk("signature", 32'(bus.signature), 32'(exp_sig));
        chk("pass", 32'(bus.pass), 32'(exp_pass));
      end
    end
  end

  task automatic run(input int n, input logic [15:0] gold, input bit gold_model,
                     input int mode, input int pulse_at);
    logic [15:0] g;
    int k;
    build_model(n, mode);
    g         = gold_model ? exp_sig : gold;
    exp_pass  = (exp_sig == g);
    exp_n     = n;
    resp_mode = mode;
    busy_cnt  = 0;
    @(negedge clk);
    bus.pattern_count = 16'(n);
    bus.golden_sig    = g;
    bus.start         = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    run_t0    = cyc;
    model_on  = 1'b1;
    for (int i = 0; i < 200 && !bus.done; i++) begin
      @(negedge clk);
      k = cyc - run_t0;
      if (k < 64) obs[k] = bus.stim;
      if (bus.busy) busy_cnt++;
      if (i == pulse_at) begin
        bus.start         = 1'b1;
        bus.pattern_count = 16'd2;
        bus.golden_sig    = ~g;
      end else begin
        bus.start = 1'b0;
      end
    end
    done_k = cyc - run_t0;
    chk("done_reached", 32'(bus.done), 32'd1);
    @(negedge clk);
    #1 model_on = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nd;
    bit uniq;
    checks = 0; errors = 0; cyc = 0; model_on = 1'b0; resp_mode = 0;
    bus.start = 1'b0; bus.pattern_count = '0; bus.golden_sig = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    chk("rst_stim", 32'(bus.stim), 32'h1F);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_sig", 32'(bus.signature), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(4, 16'h0000, 1'b0, 0, -1);
    chk("n4_busy_cycles", 32'(busy_cnt), 32'd6);
    chk("n4_done_k", 32'(done_k), 32'd6);
    chk("n4_sig", 32'(bus.signature), 32'h0000);
    chk("n4_pass", 32'(bus.pass), 32'd1);

    run(2, 16'h0003, 1'b0, 1, -1);
    chk("n2_stim0", 32'(obs[0]), 32'h1F);
    chk("n2_stim1", 32'(obs[1]), 32'h1E);
    chk("n2_sig", 32'(bus.signature), 32'h0003);
    chk("n2_pass", 32'(bus.pass), 32'd1);

    run(31, 16'h0000, 1'b1, 2, -1);
    nd = 0;
    for (int i = 0; i < 31; i++) begin
      uniq = (obs[i] != 5'h00);
      for (int j = 0; j < i; j++) if (obs[j] == obs[i]) uniq = 1'b0;
      if (uniq) nd++;
    end
    chk("n31_distinct", 32'(nd), 32'd31);
    chk("n31_pass", 32'(bus.pass), 32'd1);

    run(32, 16'h1234, 1'b0, 2, -1);
    chk("n32_wrap", 32'(obs[31]), 32'h1F);

    run(0, 16'h0001, 1'b0, 0, -1);
    chk("n0_done_k", 32'(done_k), 32'd0);
    chk("n0_pass", 32'(bus.pass), 32'd0);
    chk("n0_sig", 32'(bus.signature), 32'd0);

    run(5, 16'h0000, 1'b1, 2, 2);
    chk("ign_done_k", 32'(done_k), 32'd7);
    chk("ign_busy_cycles", 32'(busy_cnt), 32'd7);
    chk("ign_pass", 32'(bus.pass), 32'd1);

    build_model(10, 1);
    resp_mode = 1;
    @(negedge clk);
    bus.pattern_count = 16'd10; bus.golden_sig = 16'h0000; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_stim", 32'(bus.stim), 32'(seq[3]));
    chk("pre_rst_sig", 32'(bus.signature), 32'h0001);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stim", 32'(bus.stim), 32'h1F);
    chk("mid_rst_sig", 32'(bus.signature), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_pass", 32'(bus.pass), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
      chk("abort_idle", 32'(bus.busy), 32'd0);
    end

    run(6, 16'h0000, 1'b1, 2, -1);
    chk("fresh_pass", 32'(bus.pass), 32'd1);
    chk("fresh_done_k", 32'(done_k), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_stim_resp.md
BIST_STIM_RESP -- requirements
Module: bist_stim_resp

Interface
REQ-001 SHALL have parameter LAT, default 2: DUT input-to-output latency in clock cycles, legal range 1..8.
REQ-002 SHALL have parameter SEED, default 5'h1F: LFSR start state, nonzero.
REQ-003 SHALL have parameter GOLD_W, default 16: signature width; only 16 is supported.
REQ-004 SHALL have port I1294_clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-005 SHALL have port I1301_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begins a run when sampled high in IDLE or DONE.
REQ-007 SHALL have port pattern_count, input, 16 bits: number of patterns N, sampled with start.
REQ-008 SHALL have port golden_sig, input, 16 bits: expected signature, sampled with start.
REQ-009 SHALL have port dut_resp, input, 1 bit: DUT observed output.
REQ-010 SHALL have port stim, output, 5 bits: DUT stimulus, bit4..0 = I1622, I2319, I2240, I2412, I2795.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN or DRAIN.
REQ-012 SHALL have port done, output, 1 bit: high in DONE.
REQ-013 SHALL have port pass, output, 1 bit: signature == golden; valid only while done is high.
REQ-014 SHALL have port signature, output, 16 bits: current MISR state.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-016 SHALL make these transitions: IDLE/DONE --start--> RUN (N>0) or DONE (N=0); RUN --after N cycles--> DRAIN; DRAIN --after LAT cycles--> DONE.
REQ-017 SHALL, on an accepted start: latch N and golden_sig, reload the LFSR to SEED, clear signature to 0, and clear pass.
REQ-018 SHALL drive stim with LFSR state k during RUN cycle k (k = 0..N-1), where state 0 = SEED.
REQ-019 SHALL advance the LFSR as x^5+x^3+1 Fibonacci: next = {s[3:0], s[4]^s[2]}, period 31.
REQ-020 SHALL hold stim at its last RUN value during DRAIN/DONE, and at SEED in IDLE.
REQ-021 SHALL count patterns with a 16-bit counter, with no wrap (N max 65535); the LFSR wraps to SEED after 31 advances.
REQ-022 SHALL mark each RUN cycle valid in a LAT-deep shift register; the MISR captures dut_resp exactly when the delayed valid bit emerges, giving N captures total.
REQ-023 SHALL update the MISR on capture as: next = {sig[14:0],0} ^ (sig[15] ? 16'h1021 : 0) ^ {15'b0, dut_resp}.
REQ-024 SHALL, on the cycle DONE is entered, register pass = (signature == latched golden).
REQ-025 SHALL hold pass, signature and done until the next accepted start.
REQ-026 SHALL ignore start while busy; latched N/golden_sig SHALL stay unchanged.
REQ-027 SHALL treat N=0 as follows: DONE the cycle after start, signature=0, pass=(golden==0).
REQ-028 SHALL, when start occurs in DONE, behave identically to start in IDLE, with done falling in the same edge RUN is entered.

Reset
REQ-029 SHALL, while I1301_rst is high, immediately force: state=IDLE, stim=SEED, signature=0, busy=0, done=0, pass=0, counters and valid pipe=0.
REQ-030 SHALL, on reset assertion mid-RUN/DRAIN, abort the run with no done pulse; the first start after release begins a fresh run.

Structure
REQ-031 SHALL place the state enum, LFSR tap/SEED default, MISR polynomial 16'h1021 and widths in package bist_pkg.
REQ-032 SHALL implement the MISR as sub-module bist_misr16 (clk, rst, clear, en, din, sig); all other logic stays in the top.

Verification
REQ-033 SHALL cover: LAT=2, N=4, dut_resp tied 0 -> busy for 6 cycles, done, signature=16'h0000, pass=1 with golden=0.
REQ-034 SHALL cover: LAT=2, N=2, dut_resp tied 1 -> stim 5'h1F then 5'h1E, signature=16'h0003.
REQ-035 SHALL cover: N=31 -> stim visits 31 distinct nonzero values; a 32nd pattern (N=32) shows 5'h1F again.
REQ-036 SHALL cover: N=0, golden=16'h0001 -> done one cycle after start, pass=0.
REQ-037 SHALL cover: start pulsed mid-RUN -> ignored, run completes with the original N.
REQ-038 SHALL cover: reset asserted in RUN cycle 3 -> all outputs to reset values in the same cycle; a new start gives a correct fresh signature.
